// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-step shift/rotate sequencer: datapath width,
// operation encoding (matches the shifter_rotator select) and FSM states.
package shift_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_shifter_rotator.sv
// Single-position shifter/rotator datapath: y is x moved one place in the
// direction chosen by select; logical shifts fill with zero.
module shifter_rotator
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [1:0]        select,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = x;
    case (select)
      OP_SLL:  y = {x[DATA_W-2:0], 1'b0};
      OP_SRL:  y = {1'b0, x[DATA_W-1:1]};
      OP_ROL:  y = {x[DATA_W-2:0], x[DATA_W-1]};
      OP_ROR:  y = {x[0], x[DATA_W-1:1]};
      default: y = x;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-step shift/rotate sequencer: one datapath step per clock, request and
// result over valid/ready. Define SHIFT_SEQ_AMT_REDUCE_EN to trim the step count.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        op_in,
  input  logic [AMT_W-1:0]  amt_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  state_e             state_q, state_nxt;
  logic [DATA_W-1:0]  work_q;
  logic [DATA_W-1:0]  step_y;
  logic [AMT_W-1:0]   cnt_q;
  logic [AMT_W-1:0]   n_eff;
  op_e                op_q;
  logic               load;
  logic               step;

  // Rotates repeat every DATA_W steps and shifts saturate to zero after
  // DATA_W steps, so the reduced count produces the same result sooner.
  always_comb begin
    n_eff = amt_in;
`ifdef SHIFT_SEQ_AMT_REDUCE_EN
    if (op_in[1]) begin
      n_eff = AMT_W'(int'(amt_in) % DATA_W);
    end else if (int'(amt_in) > DATA_W) begin
      n_eff = AMT_W'(DATA_W);
    end
`endif
  end

  shifter_rotator u_shifter_rotator (
    .x      (work_q),
    .select (op_q),
    .y      (step_y)
  );

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = (n_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        work_q <= data_in;
        op_q   <= op_e'(op_in);
        cnt_q  <= n_eff;
      end else if (step) begin
        work_q <= step_y;
        cnt_q  <= cnt_q - AMT_W'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a cycle-level reference model and
// literal latency/result expectations; honours SHIFT_SEQ_AMT_REDUCE_EN.
module tb_shift_seq_ctrl;

  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       data_in;
  logic [1:0]       op_in;
  logic [AMT_W-1:0] amt_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       data_out;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;
  bit armed    = 1'b0;

  shift_seq_ctrl #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .op_in     (op_in),
    .amt_in    (amt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [3:0] ref_result(input logic [3:0] d, input logic [1:0] op, input int amt);
    logic [7:0] dd;
    int r;
    dd = {d, d};
    r  = amt % 4;
    case (op)
      2'b00:   ref_result = (amt >= 4) ? 4'b0000 : 4'(d << amt);
      2'b01:   ref_result = (amt >= 4) ? 4'b0000 : 4'(d >> amt);
      2'b10:   ref_result = dd[7-r -: 4];
      default: ref_result = dd[r +: 4];
    endcase
  endfunction

  function automatic int ref_steps(input logic [1:0] op, input int amt);
`ifdef SHIFT_SEQ_AMT_REDUCE_EN
    if (op[1]) ref_steps = amt % 4;
    else       ref_steps = (amt > 4) ? 4 : amt;
`else
    ref_steps = amt;
`endif
  endfunction

  // Model: phase 0 idle, 1 running (m_left steps to go), 2 result held.
  int         m_phase = 0;
  int         m_left  = 0;
  logic [3:0] m_data  = 4'b0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_data  = 4'b0000;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_data  = ref_result(data_in, op_in, int'(amt_in));
             m_left  = ref_steps(op_in, int'(amt_in));
             m_phase = (m_left == 0) ? 2 : 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model in_ready", in_ready, (m_phase == 0));
      chk("model busy", busy, (m_phase == 1));
      chk("model out_valid", out_valid, (m_phase == 2));
      if (m_phase == 2) chk("model data_out", data_out, m_data);
    end
  end

  // Called at posedge+1 with the DUT idle; counts cycles from acceptance.
  task automatic run_req(input string name, input logic [3:0] d, input logic [1:0] op,
                         input int amt, input logic [3:0] exp_d, input int exp_lat);
    int cyc;
    int busy_cyc;
    chk({name, " ready"}, in_ready, 1'b1);
    data_in  = d;
    op_in    = op;
    amt_in   = AMT_W'(amt);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 4'($urandom);
    op_in    = 2'($urandom);
    amt_in   = AMT_W'($urandom);
    cyc      = 1;
    busy_cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " busy cycles"}, busy_cyc, exp_lat - 1);
    chk({name, " data"}, data_out, exp_d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 4'b0000;
    op_in     = 2'b00;
    amt_in    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset data_out", data_out, 4'b0000);
    rst_n = 1'b1;
    armed = 1'b1;
    @(posedge clk); #1;

    run_req("sll1", 4'b1011, 2'b00, 1, 4'b0110, 2);
    run_req("ror1", 4'b1011, 2'b11, 1, 4'b1101, 2);
    run_req("rol2", 4'b1011, 2'b10, 2, 4'b1110, 3);
`ifdef SHIFT_SEQ_AMT_REDUCE_EN
    run_req("srl5", 4'b1000, 2'b01, 5, 4'b0000, 5);
    run_req("rol6", 4'b0001, 2'b10, 6, 4'b0100, 3);
`else
    run_req("srl5", 4'b1000, 2'b01, 5, 4'b0000, 6);
    run_req("rol6", 4'b0001, 2'b10, 6, 4'b0100, 7);
`endif
    run_req("srl0", 4'b1001, 2'b01, 0, 4'b1001, 1);
    run_req("rol0", 4'b0110, 2'b10, 0, 4'b0110, 1);
    run_req("sll3", 4'b0111, 2'b00, 3, 4'b1000, 4);

    // Backpressure: result must hold while requests knock on the door.
    data_in  = 4'b0011;
    op_in    = 2'b00;
    amt_in   = AMT_W'(1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp data_out", data_out, 4'b0110);
      chk("bp in_ready", in_ready, 1'b0);
      in_valid = ~in_valid;
      data_in  = ~data_in;
      @(posedge clk); #1;
    end
    chk("bp held data_out", data_out, 4'b0110);
    data_in   = 4'b0101;
    op_in     = 2'b11;
    amt_in    = AMT_W'(1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp idle after handshake", in_ready, 1'b1);
    chk("bp no valid after handshake", out_valid, 1'b0);
    run_req("bp next", 4'b0101, 2'b11, 1, 4'b1010, 2);

    // Reset in cycle 2 of a long shift discards the result.
    data_in  = 4'b1111;
    op_in    = 2'b00;
    amt_in   = AMT_W'(5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", busy, 1'b0);
    chk("midrun reset in_ready", in_ready, 1'b1);
    chk("midrun reset out_valid", out_valid, 1'b0);
    chk("midrun reset data_out", data_out, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset no valid", out_valid, 1'b0);
    run_req("post reset", 4'b1100, 2'b01, 2, 4'b0011, 3);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
